// File: rtl/hilo_div.sv
// Multi-cycle radix-2 restoring divider producing LO (quotient) and HI (remainder)
// for signed and unsigned divides, with pipeline stall, annul and divide-by-zero reporting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// PREP  | operands converted to magnitudes; b == 0 short-circuits to DONE
// ITER  | WIDTH restoring steps, one quotient bit per cycle, MSB first
// FIX   | sign correction, quot/rem loaded
// DONE  | done pulse for one cycle, stall released
module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rr;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] b_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // a_q doubles as the dividend shift register and the quotient accumulator.
  always_comb begin
    rr    = {r_q, a_q[WIDTH-1]};
    trial = rr - {1'b0, b_q};
    b_mag = sb_q ? -b_q : b_q;

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sa_d    = a[WIDTH-1] & signed_div;
          sb_d    = b[WIDTH-1] & signed_div;
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_mag == '0) begin
          quot_d  = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = sa_q ? -a_q : a_q;
          b_d     = b_mag;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        // trial[WIDTH] set means the subtraction borrowed: restore.
        r_d   = trial[WIDTH] ? rr[WIDTH-1:0] : trial[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        quot_d  = (sa_q ^ sb_q) ? -a_q : a_q;
        rem_d   = sa_q ? -r_q : r_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush discards the operation and leaves the architectural results alone.
    if (annul) begin
      state_d = IDLE;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
    end
  end

  assign busy        = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign stall       = ~rst & ~annul & (((state_q == IDLE) & start) | busy);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed bench for hilo_div: cycle-exact timing, signed/unsigned results,
// divide-by-zero, overflow, annul, start collisions and mid-operation reset.
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  hilo_div #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the drive slot of the next cycle (1 time unit after the rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called in the drive slot of cycle 0. start is held through the done cycle
  // and operands are scrambled after cycle 0, so sampling and start-while-busy
  // are exercised on every run.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int lat);
    a = av; b = bv; signed_div = sg; start = 1'b1;
    #1;
    check({tag, ".stall_c0"}, 64'(stall), 64'd1);
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      a = ~av; b = ~bv; signed_div = ~sg;
      #1;
      if (c < lat) begin
        check($sformatf("%s.done_c%0d", tag, c), 64'(done), 64'd0);
        check($sformatf("%s.stall_c%0d", tag, c), 64'(stall), 64'd1);
        check($sformatf("%s.busy_c%0d", tag, c), 64'(busy), 64'd1);
      end else begin
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".stall_done"}, 64'(stall), 64'd0);
        check({tag, ".busy_done"}, 64'(busy), 64'd0);
        check({tag, ".quot"}, 64'(quot), 64'(eq));
        check({tag, ".rem"}, 64'(rem), 64'(er));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
      end
    end
    next_cycle();
    start = 1'b0;
    #1;
    check({tag, ".done_after"}, 64'(done), 64'd0);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".stall_after"}, 64'(stall), 64'd0);
    check({tag, ".quot_hold"}, 64'(quot), 64'(eq));
    check({tag, ".dbz_hold"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin : main
    bit seen_done;

    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; a = 32'd5; b = 32'd1;
    #1;
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.quot", 64'(quot), 64'd0);
    check("rst.rem", 64'(rem), 64'd0);
    check("rst.dbz", 64'(div_by_zero), 64'd0);
    next_cycle();
    start = 1'b0;
    next_cycle();

    // Release reset and start in the same cycle: accepted on the next edge.
    rst = 1'b0;
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35);
    next_cycle();
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35);
    next_cycle();
    do_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 35);
    next_cycle();
    do_div("dbz", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
    next_cycle();
    do_div("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 35);
    next_cycle();
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35);
    next_cycle();
    do_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 35);
    next_cycle();
    do_div("s_dbz", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 2);
    next_cycle();
    do_div("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 35);

    // Annul at cycle 10: prior results (14, -2, dbz 0) must survive.
    next_cycle();
    a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      start = 1'b0;
    end
    annul = 1'b1;
    #1;
    check("annul.stall_c10", 64'(stall), 64'd0);
    next_cycle();
    annul = 1'b0;
    #1;
    check("annul.busy_c11", 64'(busy), 64'd0);
    check("annul.stall_c11", 64'(stall), 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      #1;
      if (done) seen_done = 1'b1;
    end
    check("annul.no_done", 64'(seen_done), 64'd0);
    check("annul.quot_kept", 64'(quot), 64'd14);
    check("annul.rem_kept", 64'(rem), 64'hFFFF_FFFE);
    check("annul.dbz_kept", 64'(div_by_zero), 64'd0);

    // start and annul together in IDLE: nothing starts.
    next_cycle();
    a = 32'd8; b = 32'd0; start = 1'b1; annul = 1'b1;
    #1;
    check("coll.stall", 64'(stall), 64'd0);
    next_cycle();
    start = 1'b0; annul = 1'b0;
    #1;
    check("coll.busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("coll.idle", 64'(seen_done), 64'd0);
    check("coll.dbz_kept", 64'(div_by_zero), 64'd0);
    check("coll.quot_kept", 64'(quot), 64'd14);

    // Reset at cycle 20 of an operation, restart at cycle 22.
    next_cycle();
    a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rstmid.stall", 64'(stall), 64'd0);
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.done", 64'(done), 64'd0);
    check("rstmid.quot", 64'(quot), 64'd0);
    check("rstmid.rem", 64'(rem), 64'd0);
    check("rstmid.dbz", 64'(div_by_zero), 64'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rstmid.done_c21", 64'(done), 64'd0);
    check("rstmid.busy_c21", 64'(busy), 64'd0);
    next_cycle();
    do_div("rst_restart", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
